// File: rtl/mm_stream_tx.sv
// Transmit side of the matrix-multiplier load protocol.
// Streams buffered A then B row-major with col/row markers, then tracks the core's busy handshake.
module mm_stream_tx #(
  parameter int DW       = 8,
  parameter int MAX_ELEM = 16,
  parameter int DIM_W    = 5,
  parameter int TIMEOUT  = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             wr_sel,
  input  logic [3:0]       wr_addr,
  input  logic [DW-1:0]    wr_data,
  input  logic [DIM_W-1:0] a_rows,
  input  logic [DIM_W-1:0] a_cols,
  input  logic [DIM_W-1:0] b_rows,
  input  logic [DIM_W-1:0] b_cols,
  input  logic             start,
  input  logic             dut_busy,
  output logic             ready,
  output logic [DW-1:0]    in_data,
  output logic             col_end,
  output logic             row_end,
  output logic             done,
  output logic             err
);

  localparam int PW = 2 * DIM_W;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_HI, WAIT_LO} state_t;

  state_t           state_q, state_d;
  logic [DIM_W-1:0] a_rows_q, a_rows_d, a_cols_q, a_cols_d;
  logic [DIM_W-1:0] b_rows_q, b_rows_d, b_cols_q, b_cols_d;
  logic [DIM_W-1:0] r_q, r_d, c_q, c_d;
  logic [3:0]       idx_q, idx_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [DW-1:0]    in_data_q, in_data_d;
  logic             col_end_q, col_end_d, row_end_q, row_end_d;
  logic             done_q, done_d, err_q, err_d;

  logic [DW-1:0]    mem_a [MAX_ELEM];
  logic [DW-1:0]    mem_b [MAX_ELEM];

  logic             wr_ok, accept, dims_bad, last_c, last_e, tmr_hit;
  logic [PW-1:0]    a_area, b_area;
  logic [DIM_W-1:0] cur_rows, cur_cols, ld_rows, ld_cols;
  logic             ld_valid, ld_b;
  logic [DW-1:0]    a_rd, b_rd;

  assign ready   = (state_q == IDLE) && !dut_busy;
  assign accept  = start && ready;
  assign wr_ok   = wr_en && (state_q == IDLE) && (32'(wr_addr) < MAX_ELEM);
  assign a_area  = PW'(a_rows) * PW'(a_cols);
  assign b_area  = PW'(b_rows) * PW'(b_cols);
  assign dims_bad = (a_rows == '0) || (a_cols == '0) || (b_rows == '0) || (b_cols == '0) ||
                    (a_area > PW'(MAX_ELEM)) || (b_area > PW'(MAX_ELEM));

  assign cur_rows = (state_q == SEND_B) ? b_rows_q : a_rows_q;
  assign cur_cols = (state_q == SEND_B) ? b_cols_q : a_cols_q;
  assign last_c   = (c_q == cur_cols - DIM_W'(1));
  assign last_e   = last_c && (r_q == cur_rows - DIM_W'(1));
  assign tmr_hit  = (((state_q == WAIT_HI) && !dut_busy) || ((state_q == WAIT_LO) && dut_busy)) &&
                    (tmr_q == TW'(TIMEOUT - 1));

  // Element buffers are deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      if (wr_sel) mem_b[wr_addr] <= wr_data;
      else        mem_a[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_rows_q  <= '0;
      a_cols_q  <= '0;
      b_rows_q  <= '0;
      b_cols_q  <= '0;
      r_q       <= '0;
      c_q       <= '0;
      idx_q     <= '0;
      tmr_q     <= '0;
      in_data_q <= '0;
      col_end_q <= 1'b0;
      row_end_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_rows_q  <= a_rows_d;
      a_cols_q  <= a_cols_d;
      b_rows_q  <= b_rows_d;
      b_cols_q  <= b_cols_d;
      r_q       <= r_d;
      c_q       <= c_d;
      idx_q     <= idx_d;
      tmr_q     <= tmr_d;
      in_data_q <= in_data_d;
      col_end_q <= col_end_d;
      row_end_q <= row_end_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Counters track the element that will sit in the output register after this edge.
  always_comb begin
    state_d  = state_q;
    a_rows_d = a_rows_q;
    a_cols_d = a_cols_q;
    b_rows_d = b_rows_q;
    b_cols_d = b_cols_q;
    r_d      = r_q;
    c_d      = c_q;
    idx_d    = idx_q;
    tmr_d    = tmr_q;
    ld_valid = 1'b0;
    ld_b     = 1'b0;
    ld_rows  = a_rows_q;
    ld_cols  = a_cols_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_rows_d = a_rows;
          a_cols_d = a_cols;
          b_rows_d = b_rows;
          b_cols_d = b_cols;
          if (!dims_bad) begin
            state_d  = SEND_A;
            r_d      = '0;
            c_d      = '0;
            idx_d    = '0;
            ld_valid = 1'b1;
            ld_rows  = a_rows;
            ld_cols  = a_cols;
          end
        end
      end
      SEND_A, SEND_B: begin
        if (last_e) begin
          r_d   = '0;
          c_d   = '0;
          idx_d = '0;
        end else begin
          c_d   = last_c ? '0 : c_q + DIM_W'(1);
          r_d   = last_c ? r_q + DIM_W'(1) : r_q;
          idx_d = idx_q + 4'd1;
        end
        if (state_q == SEND_A) begin
          ld_valid = 1'b1;
          ld_b     = last_e;
          ld_rows  = last_e ? b_rows_q : a_rows_q;
          ld_cols  = last_e ? b_cols_q : a_cols_q;
          if (last_e) state_d = SEND_B;
        end else begin
          ld_valid = !last_e;
          ld_b     = 1'b1;
          ld_rows  = b_rows_q;
          ld_cols  = b_cols_q;
          if (last_e) begin
            state_d = WAIT_HI;
            tmr_d   = '0;
          end
        end
      end
      WAIT_HI: begin
        if (dut_busy) begin
          state_d = WAIT_LO;
          tmr_d   = '0;
        end else if (tmr_hit) state_d = IDLE;
        else tmr_d = tmr_q + TW'(1);
      end
      WAIT_LO: begin
        if (!dut_busy || tmr_hit) state_d = IDLE;
        else tmr_d = tmr_q + TW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // A write landing on the accept edge is forwarded so the stream sees post-write contents.
  always_comb begin
    a_rd = mem_a[idx_d];
    b_rd = mem_b[idx_d];
    if (wr_ok && !wr_sel && (wr_addr == idx_d)) a_rd = wr_data;
    if (wr_ok && wr_sel && (wr_addr == idx_d))  b_rd = wr_data;
    in_data_d = '0;
    col_end_d = 1'b0;
    row_end_d = 1'b0;
    if (ld_valid) begin
      in_data_d = ld_b ? b_rd : a_rd;
      col_end_d = (c_d == ld_cols - DIM_W'(1));
      row_end_d = col_end_d && (r_d == ld_rows - DIM_W'(1));
    end
    done_d = ((state_q == IDLE) && accept && dims_bad) ||
             ((state_q == WAIT_LO) && !dut_busy) || tmr_hit;
    err_d  = err_q;
    if ((state_q == IDLE) && accept) err_d = dims_bad;
    if (tmr_hit) err_d = 1'b1;
  end

  assign in_data = in_data_q;
  assign col_end = col_end_q;
  assign row_end = row_end_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_mm_stream_tx.sv
// Self-checking bench for mm_stream_tx: a job table driven through a scoreboard queue,
// followed by hand-written reset, busy-gating, timeout and write-forwarding sequences.
module tb_mm_stream_tx;

  typedef struct packed {
    logic [4:0]       a_rows;
    logic [4:0]       a_cols;
    logic [4:0]       b_rows;
    logic [4:0]       b_cols;
    logic [15:0][7:0] a_vals;
    logic [15:0][7:0] b_vals;
    logic             exp_err;
    int               busy_cycles;
  } job_t;

  typedef struct packed {
    logic [7:0] data;
    logic       ce;
    logic       re;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic       wr_sel = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [4:0] a_rows = '0, a_cols = '0, b_rows = '0, b_cols = '0;
  logic       start = 1'b0;
  logic       dut_busy = 1'b0;
  logic       ready;
  logic [7:0] in_data;
  logic       col_end, row_end, done, err;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  job_t jobs[8];

  mm_stream_tx #(.DW(8), .MAX_ELEM(16), .DIM_W(5), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .a_rows(a_rows), .a_cols(a_cols), .b_rows(b_rows),
    .b_cols(b_cols), .start(start), .dut_busy(dut_busy), .ready(ready),
    .in_data(in_data), .col_end(col_end), .row_end(row_end), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic writeBuf(input logic sel, input logic [3:0] addr, input logic [7:0] data);
    wr_en = 1'b1;
    wr_sel = sel;
    wr_addr = addr;
    wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic loadJob(input int j);
    int na, nb;
    na = int'(jobs[j].a_rows) * int'(jobs[j].a_cols);
    nb = int'(jobs[j].b_rows) * int'(jobs[j].b_cols);
    for (int k = 0; k < na && k < 16; k++) writeBuf(1'b0, 4'(k), jobs[j].a_vals[k]);
    for (int k = 0; k < nb && k < 16; k++) writeBuf(1'b1, 4'(k), jobs[j].b_vals[k]);
  endtask

  task automatic pushMatrix(input int rows, input int cols, input logic [15:0][7:0] vals);
    exp_t e;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        e.data = vals[r * cols + c];
        e.ce   = (c == cols - 1);
        e.re   = (c == cols - 1) && (r == rows - 1);
        sb.push_back(e);
      end
    end
  endtask

  // Starts job j and checks everything up to the first cycle after B's last element.
  task automatic streamJob(input int j, input bit load);
    job_t jb;
    exp_t e;
    int   n;
    jb = jobs[j];
    if (load && !jb.exp_err) loadJob(j);
    checkOutput($sformatf("ready_before_j%0d", j), 32'(ready), 1);
    a_rows = jb.a_rows;
    a_cols = jb.a_cols;
    b_rows = jb.b_rows;
    b_cols = jb.b_cols;
    start = 1'b1;
    if (!jb.exp_err) begin
      pushMatrix(int'(jb.a_rows), int'(jb.a_cols), jb.a_vals);
      pushMatrix(int'(jb.b_rows), int'(jb.b_cols), jb.b_vals);
    end
    tick();
    start = 1'b0;
    if (jb.exp_err) begin
      checkOutput($sformatf("bad_err_j%0d", j), 32'(err), 1);
      checkOutput($sformatf("bad_done_j%0d", j), 32'(done), 1);
      checkOutput($sformatf("bad_quiet_j%0d", j), 32'({in_data, col_end, row_end}), 0);
      tick();
      checkOutput($sformatf("bad_done_clear_j%0d", j), 32'(done), 0);
      checkOutput($sformatf("bad_err_sticky_j%0d", j), 32'(err), 1);
      checkOutput($sformatf("bad_quiet2_j%0d", j), 32'({in_data, col_end, row_end}), 0);
      checkOutput($sformatf("bad_ready_j%0d", j), 32'(ready), 1);
    end else begin
      checkOutput($sformatf("err_clear_j%0d", j), 32'(err), 0);
      n = 0;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput($sformatf("stream_j%0d_e%0d", j, n), 32'({in_data, col_end, row_end}), 32'(e));
        n++;
        tick();
      end
      checkOutput($sformatf("tail_zero_j%0d", j), 32'({in_data, col_end, row_end}), 0);
      checkOutput($sformatf("not_ready_wait_j%0d", j), 32'(ready), 0);
    end
  endtask

  task automatic finishJob(input int busy_cycles);
    dut_busy = 1'b1;
    tick();
    repeat (busy_cycles) tick();
    checkOutput("done_low_while_busy", 32'(done), 0);
    dut_busy = 1'b0;
    tick();
    checkOutput("done_pulse", 32'(done), 1);
    checkOutput("done_no_err", 32'(err), 0);
    tick();
    checkOutput("done_one_cycle", 32'(done), 0);
    checkOutput("ready_after_done", 32'(ready), 1);
  endtask

  task automatic applyStimulus(input int j);
    streamJob(j, 1'b1);
    if (!jobs[j].exp_err) finishJob(jobs[j].busy_cycles);
  endtask

  task automatic setJob(input int j, input int ar, input int ac, input int br, input int bc,
                        input logic bad, input int busy);
    jobs[j] = '0;
    jobs[j].a_rows = 5'(ar);
    jobs[j].a_cols = 5'(ac);
    jobs[j].b_rows = 5'(br);
    jobs[j].b_cols = 5'(bc);
    jobs[j].exp_err = bad;
    jobs[j].busy_cycles = busy;
  endtask

  initial begin
    setJob(0, 2, 2, 2, 2, 1'b0, 2);
    for (int k = 0; k < 4; k++) begin
      jobs[0].a_vals[k] = 8'(k + 1);
      jobs[0].b_vals[k] = 8'(k + 5);
    end
    setJob(1, 1, 4, 4, 1, 1'b0, 1);
    jobs[1].a_vals[0] = 8'h01;
    jobs[1].a_vals[1] = 8'hFF;
    jobs[1].a_vals[2] = 8'h02;
    jobs[1].a_vals[3] = 8'hFE;
    for (int k = 0; k < 4; k++) jobs[1].b_vals[k] = 8'h03;
    setJob(2, 0, 2, 2, 2, 1'b1, 0);
    setJob(3, 5, 4, 2, 2, 1'b1, 0);
    setJob(4, 3, 2, 3, 2, 1'b0, 3);
    for (int k = 0; k < 6; k++) begin
      jobs[4].a_vals[k] = 8'(10 + k);
      jobs[4].b_vals[k] = 8'(40 + k);
    end
    setJob(5, 4, 4, 4, 4, 1'b0, 0);
    for (int k = 0; k < 16; k++) begin
      jobs[5].a_vals[k] = 8'(k * 3 + 1);
      jobs[5].b_vals[k] = 8'(200 + k);
    end
    setJob(6, 2, 2, 4, 5, 1'b1, 0);
    setJob(7, 1, 1, 1, 1, 1'b0, 1);
    jobs[7].a_vals[0] = 8'h11;
    jobs[7].b_vals[0] = 8'h22;

    repeat (2) tick();
    rst = 1'b0;
    checkOutput("reset_outputs", 32'({in_data, col_end, row_end}), 0);
    checkOutput("reset_done", 32'(done), 0);
    checkOutput("reset_err", 32'(err), 0);
    checkOutput("reset_ready", 32'(ready), 1);

    for (int j = 0; j < 8; j++) applyStimulus(j);

    // Reset on the third A element, then a job reusing the retained buffers.
    loadJob(0);
    a_rows = 5'd2; a_cols = 5'd2; b_rows = 5'd2; b_cols = 5'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checkOutput("t4_third_elem", 32'({in_data, col_end, row_end}), 32'({8'd3, 1'b0, 1'b0}));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t4_outputs_zero", 32'({in_data, col_end, row_end}), 0);
    checkOutput("t4_done_zero", 32'(done), 0);
    checkOutput("t4_ready", 32'(ready), 1);
    streamJob(0, 1'b0);
    finishJob(1);

    // Start is ignored while the core is busy.
    dut_busy = 1'b1;
    #1;
    checkOutput("t5_not_ready", 32'(ready), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("t5_ignored_quiet", 32'({in_data, col_end, row_end}), 0);
    tick();
    checkOutput("t5_ignored_quiet2", 32'({in_data, col_end, row_end}), 0);
    checkOutput("t5_ignored_done", 32'(done), 0);
    dut_busy = 1'b0;
    #1;
    checkOutput("t5_ready_again", 32'(ready), 1);

    // WAIT_HI timeout with busy stuck low; a write attempted here must be dropped.
    streamJob(0, 1'b0);
    writeBuf(1'b0, 4'd0, 8'hEE);
    repeat (6) tick();
    checkOutput("t5_hi_no_early_done", 32'(done), 0);
    tick();
    checkOutput("t5_hi_timeout_done", 32'(done), 1);
    checkOutput("t5_hi_timeout_err", 32'(err), 1);
    tick();
    checkOutput("t5_hi_done_clear", 32'(done), 0);
    checkOutput("t5_hi_err_sticky", 32'(err), 1);

    // WAIT_LO timeout with busy stuck high; stream also proves the dropped write.
    streamJob(0, 1'b0);
    dut_busy = 1'b1;
    tick();
    repeat (7) tick();
    checkOutput("t5_lo_no_early_done", 32'(done), 0);
    tick();
    checkOutput("t5_lo_timeout_done", 32'(done), 1);
    checkOutput("t5_lo_timeout_err", 32'(err), 1);
    dut_busy = 1'b0;
    tick();
    checkOutput("t5_lo_done_clear", 32'(done), 0);

    // Write on the accept edge is seen by the stream.
    loadJob(7);
    a_rows = 5'd1; a_cols = 5'd1; b_rows = 5'd1; b_cols = 5'd1;
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 8'h77;
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    checkOutput("fwd_a0", 32'({in_data, col_end, row_end}), 32'({8'h77, 1'b1, 1'b1}));
    checkOutput("fwd_err_clear", 32'(err), 0);
    tick();
    checkOutput("fwd_b0", 32'({in_data, col_end, row_end}), 32'({8'h22, 1'b1, 1'b1}));
    tick();
    checkOutput("fwd_tail", 32'({in_data, col_end, row_end}), 0);
    finishJob(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
